seven_window_feeder: RTL and testbench

Producer side of the gradient stage's window interface. Accepts a raster-ordered stream of 8-bit pixels and assembles them into a 7x7 window, `seven_buffer_out`. It then presents that window to the gradient stage and steps `grad_shift` through the three computation phases (left columns, right columns, bottom rows), one phase per downstream handshake. It sits between the pixel source (frame memory reader) and the gradient stage.

---
 rtl/seven_window_feeder.sv | 141 ++++++++++++++
 tb/tb_seven_window_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_window_feeder.sv
`default_nettype none
// == seven_window_feeder: raster 8-bit pixels -> 7x7 window, emitted in three gradient phases. rev 1.0 ==
// == Optional SEVEN_FEEDER_PREFETCH_EN: ping-pong banks so filling overlaps emission.               ==
module seven_window_feeder #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [PIX_W-1:0]               pix_in,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic                           out_ready,
  output logic [0:6][0:6][PIX_W-1:0]     seven_buffer_out,
  output logic [1:0]                     grad_shift,
  output logic                           win_valid,
  output logic                           win_done,
  output logic [CNT_W-1:0]               win_count
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT_L = 2'd1,
    EMIT_R = 2'd2,
    EMIT_B = 2'd3
  } state_t;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_L    = 2'b10;
  localparam logic [1:0] GS_R    = 2'b01;
  localparam logic [1:0] GS_B    = 2'b11;

  state_t                        state;
  logic [2:0]                    row;
  logic [2:0]                    col;
  logic [0:6][0:6][PIX_W-1:0]    bank_a;
  logic                          accept;
  logic                          last;
  logic                          emit_end;
  logic                          fill_complete;
  logic                          start_win;

  assign accept    = pix_valid && pix_ready;
  assign last      = (row == 3'd6) && (col == 3'd6);
  assign emit_end  = (state == EMIT_B) && out_ready;
  // A new window starts either from idle or directly on the final handshake of the previous one.
  assign start_win = fill_complete && ((state == FILL) || emit_end);

`ifdef SEVEN_FEEDER_PREFETCH_EN
  logic [0:6][0:6][PIX_W-1:0]    bank_b;
  logic                          fill_sel;
  logic                          full;

  assign fill_complete    = (accept && last) || full;
  assign pix_ready        = !flush && !full;
  assign seven_buffer_out = fill_sel ? bank_a : bank_b;
`else
  assign fill_complete    = accept && last;
  assign pix_ready        = !flush && (state == FILL);
  assign seven_buffer_out = bank_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      grad_shift <= GS_IDLE;
      win_valid  <= 1'b0;
      win_done   <= 1'b0;
      win_count  <= '0;
      row        <= 3'd0;
      col        <= 3'd0;
      bank_a     <= '0;
`ifdef SEVEN_FEEDER_PREFETCH_EN
      bank_b     <= '0;
      fill_sel   <= 1'b0;
      full       <= 1'b0;
`endif
    end else begin
      win_done <= 1'b0;
      if (flush) begin
        state      <= FILL;
        grad_shift <= GS_IDLE;
        win_valid  <= 1'b0;
        row        <= 3'd0;
        col        <= 3'd0;
`ifdef SEVEN_FEEDER_PREFETCH_EN
        full       <= 1'b0;
`endif
      end else begin
        if (accept) begin
`ifdef SEVEN_FEEDER_PREFETCH_EN
          if (fill_sel) bank_b[row][col] <= pix_in;
          else          bank_a[row][col] <= pix_in;
`else
          bank_a[row][col] <= pix_in;
`endif
          if (col == 3'd6) begin
            col <= 3'd0;
            row <= last ? 3'd0 : row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end

        case (state)
          EMIT_L: if (out_ready) begin
            state      <= EMIT_R;
            grad_shift <= GS_R;
          end
          EMIT_R: if (out_ready) begin
            state      <= EMIT_B;
            grad_shift <= GS_B;
          end
          EMIT_B: if (out_ready) begin
            state      <= FILL;
            grad_shift <= GS_IDLE;
            win_valid  <= 1'b0;
            win_count  <= win_count + CNT_W'(1);
            win_done   <= 1'b1;
          end
          default: ;
        endcase

        // Overrides the return to FILL when the next window is already complete.
        if (start_win) begin
          state      <= EMIT_L;
          grad_shift <= GS_L;
          win_valid  <= 1'b1;
        end

`ifdef SEVEN_FEEDER_PREFETCH_EN
        if (start_win) fill_sel <= ~fill_sel;
        full <= fill_complete && (state != FILL) && !emit_end;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_window_feeder.sv
`default_nettype none
// Randomized + directed bench for seven_window_feeder against a pixel-stream model.
module tb_seven_window_feeder;
  localparam int PIX_W = 8;
  localparam int CNT_W = 16;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush;
  logic [PIX_W-1:0]            pix_in;
  logic                        pix_valid;
  logic                        pix_ready;
  logic                        out_ready;
  logic [0:6][0:6][PIX_W-1:0]  seven_buffer_out;
  logic [1:0]                  grad_shift;
  logic                        win_valid;
  logic                        win_done;
  logic [CNT_W-1:0]            win_count;

  always #5 clk = ~clk;

  seven_window_feeder #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .out_ready(out_ready), .seven_buffer_out(seven_buffer_out),
    .grad_shift(grad_shift), .win_valid(win_valid), .win_done(win_done), .win_count(win_count)
  );

  int errors = 0;
  int checks = 0;

  // Model: pixels collected so far, the window on display and which phase (0 idle, 1..3) is shown.
  logic [7:0] m_win  [49];
  logic [7:0] m_fill [49];
  int         m_nfill;
  int         m_phase;
  int         m_count;
  bit         m_done;
  bit         m_acc;
  logic [1:0] gs_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input logic [0:6][0:6][7:0] act,
                           input logic [0:6][0:6][7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_ready(input bit f);
`ifdef SEVEN_FEEDER_PREFETCH_EN
    return !f && (m_nfill < 49);
`else
    return !f && (m_phase == 0);
`endif
  endfunction

  task automatic m_step(input bit r, input bit f, input bit pv, input logic [7:0] pin, input bit ordy);
    bit take;
    m_acc = 1'b0;
    if (r) begin
      m_phase = 0; m_nfill = 0; m_count = 0; m_done = 1'b0;
      foreach (m_win[i]) m_win[i] = 8'd0;
    end else begin
      m_done = 1'b0;
      if (f) begin
        m_phase = 0; m_nfill = 0;
      end else begin
        m_acc = pv && m_ready(1'b0);
        if (m_acc) begin
          m_fill[m_nfill] = pin;
          m_nfill++;
        end
        take = 1'b0;
        if (m_phase == 0) take = (m_nfill == 49);
        else if (ordy) begin
          if (m_phase < 3) m_phase++;
          else begin
            m_count = (m_count + 1) % 65536;
            m_done  = 1'b1;
            m_phase = 0;
            take    = (m_nfill == 49);
          end
        end
        if (take) begin
          m_win   = m_fill;
          m_phase = 1;
          m_nfill = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [0:6][0:6][7:0] expw;
    check("grad_shift", grad_shift, gs_tab[m_phase]);
    check("win_valid", win_valid, m_phase != 0);
    check("win_done", win_done, m_done);
    check("win_count", win_count, m_count);
    if (m_phase != 0) begin
      for (int i = 0; i < 49; i++) expw[i/7][i%7] = m_win[i];
      check_win("window", seven_buffer_out, expw);
    end
  endtask

  // One clock: check outputs of the previous edge, drive new inputs, check pix_ready, advance the model.
  task automatic cyc(input bit r, input bit f, input bit pv, input logic [7:0] pin, input bit ordy);
    @(negedge clk);
    compare_outputs();
    rst = r; flush = f; pix_valid = pv; pix_in = pin; out_ready = ordy;
    #1;
    if (!r) check("pix_ready", pix_ready, m_ready(f));
    m_step(r, f, pv, pin, ordy);
  endtask

  initial begin
    int n;
    int stall;
    int start;
    int next_pix;
    bit o;

    rst = 1'b1; flush = 1'b0; pix_valid = 1'b0; pix_in = '0; out_ready = 1'b0;
    m_step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);

    // Reset state
    cyc(0, 0, 0, 8'd0, 0);
    check("rst_grad", grad_shift, 2'b00);
    check("rst_valid", win_valid, 1'b0);
    check("rst_count", win_count, 16'd0);
    check("rst_ready", pix_ready, 1'b1);
    check_win("rst_window", seven_buffer_out, '0);

    // Basic fill and emit
    next_pix = 0; n = 0;
    while (m_count == 0 && n < 300) begin
      cyc(0, 0, next_pix < 49, 8'(next_pix), 1);
      if (m_acc) next_pix++;
      n++;
    end
    check("basic_timeout", n >= 300, 1'b0);
    cyc(0, 0, 0, 8'd0, 0);
    check("basic_w00", seven_buffer_out[0][0], 8'd0);
    check("basic_w34", seven_buffer_out[3][4], 8'd25);
    check("basic_w66", seven_buffer_out[6][6], 8'd48);
    check("basic_model_w34", m_win[25], 8'd25);
    check("basic_count", win_count, 16'd1);
    check("basic_ready", pix_ready, 1'b1);

    // Downstream stall of 5 cycles in EMIT_R
    cyc(0, 1, 0, 8'd0, 1);
    n = 0; stall = 0; start = m_count;
    while (m_count == start && n < 300) begin
      o = 1'b1;
      if (m_phase == 2 && stall < 5) begin o = 1'b0; stall++; end
      cyc(0, 0, 1, 8'($urandom), o);
      n++;
    end
    check("stall_timeout", n >= 300, 1'b0);
    check("stall_cycles", stall, 5);

    // Bubbly source
    cyc(0, 1, 0, 8'd0, 1);
    next_pix = 0; n = 0; start = m_count;
    while (m_count == start && n < 400) begin
      cyc(0, 0, (n % 2 == 0) && next_pix < 49, 8'(next_pix), 1);
      if (m_acc) next_pix++;
      n++;
    end
    check("bubbly_timeout", n >= 400, 1'b0);
    cyc(0, 0, 0, 8'd0, 0);
    check("bubbly_w00", seven_buffer_out[0][0], 8'd0);
    check("bubbly_w25", seven_buffer_out[2][5], 8'd19);
    check("bubbly_w66", seven_buffer_out[6][6], 8'd48);

    // Flush mid-fill
    cyc(0, 1, 0, 8'd0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'(50 + i), 1);
    cyc(0, 1, 1, 8'd77, 1);
    next_pix = 100; n = 0; start = m_count;
    while (m_count == start && n < 300) begin
      cyc(0, 0, next_pix < 149, 8'(next_pix), 1);
      if (m_acc) next_pix++;
      n++;
    end
    check("flush_timeout", n >= 300, 1'b0);
    cyc(0, 0, 0, 8'd0, 0);
    check("flush_w00", seven_buffer_out[0][0], 8'd100);
    check("flush_w66", seven_buffer_out[6][6], 8'd148);
    check("flush_model_w66", m_win[48], 8'd148);
    check("flush_count", win_count, 16'(start + 1));

    // Random traffic with occasional flush
    for (int i = 0; i < 1500; i++)
      cyc(0, ($urandom % 64) == 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);

    // Reset during EMIT_L
    cyc(0, 1, 0, 8'd0, 1);
    next_pix = 0; n = 0;
    while (m_phase != 1 && n < 300) begin
      cyc(0, 0, next_pix < 49, 8'(next_pix + 1), 0);
      if (m_acc) next_pix++;
      n++;
    end
    check("rstmid_timeout", n >= 300, 1'b0);
    cyc(1, 0, 0, 8'd0, 1);
    cyc(0, 0, 0, 8'd0, 0);
    check("rstmid_grad", grad_shift, 2'b00);
    check("rstmid_valid", win_valid, 1'b0);
    check("rstmid_count", win_count, 16'd0);
    check_win("rstmid_window", seven_buffer_out, '0);

`ifdef SEVEN_FEEDER_PREFETCH_EN
    // Back-to-back windows: 196 accepts then three more cycles
    for (int i = 0; i < 196; i++) cyc(0, 0, 1, 8'($urandom), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'd0, 1);
    cyc(0, 0, 0, 8'd0, 1);
    check("b2b_count", win_count, 16'd4);
`endif

    repeat (3) cyc(0, 0, 0, 8'd0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
